// File: rtl/fpcvt_seq_if.sv
// Handshake bundle for the sample-to-float converter: sample in, sign/exponent/significand out.
interface fpcvt_seq_if #(
    parameter int W  = 12,
    parameter int EW = 3,
    parameter int FW = 4
);
    logic [W-1:0]  D;
    logic          in_valid;
    logic          in_ready;
    logic          S;
    logic [EW-1:0] E;
    logic [FW-1:0] F;
    logic          sat;
    logic          out_valid;
    logic          out_ready;

    // Sample source / downstream consumer side
    modport master (
        output D, in_valid, out_ready,
        input  in_ready, S, E, F, sat, out_valid
    );

    // Converter side
    modport slave (
        input  D, in_valid, out_ready,
        output in_ready, S, E, F, sat, out_valid
    );
endinterface

// File: rtl/fpcvt_seq.sv
// Iterative two's-complement to (S, E, F) converter.
// The magnitude is normalised one bit per clock, then rounded and saturated in a single
// cycle; the result is held until the consumer accepts it. One conversion in flight.
module fpcvt_seq #(
    parameter int W     = 12,
    parameter int EW    = 3,
    parameter int FW    = 4,
    parameter int ROUND = 1
) (
    input  logic        clk,
    input  logic        rst,
    fpcvt_seq_if.slave  io_bus
);
    localparam int SPAN = W - FW;
    localparam int CW   = $clog2(SPAN + 2);
    localparam int EMAX = (1 << EW) - 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_NORM = 2'd1;
    localparam logic [1:0] S_RND  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]    r_state;
    logic [W-1:0]  r_sh;
    logic [CW-1:0] r_cnt;
    logic          r_s;
    logic [EW-1:0] r_e;
    logic [FW-1:0] r_f;
    logic          r_sat;
    logic          r_outValid;

    logic [W-1:0]  w_mag;
    logic          w_normDone;
    logic [CW-1:0] w_er;
    logic [FW-1:0] w_frTop;
    logic          w_r;
    logic [CW:0]   w_erRnd;
    logic [FW-1:0] w_frRnd;
    logic          w_sat;

    // The most negative sample maps to 2^(W-1), which still fits as a W-bit unsigned value
    assign w_mag      = io_bus.D[W-1] ? W'(-io_bus.D) : io_bus.D;
    assign w_normDone = r_sh[W-1] || (r_cnt == CW'(SPAN));

    assign w_er    = CW'(SPAN) - r_cnt;
    assign w_frTop = r_sh[W-1 -: FW];
    assign w_r     = (ROUND != 0) ? r_sh[SPAN-1] : 1'b0;

    // Round half-up; a carry out of an all-ones significand renormalises into the exponent
    always_comb begin
        w_erRnd = {1'b0, w_er};
        w_frRnd = w_frTop;
        if (w_r) begin
            if (&w_frTop) begin
                w_frRnd = {1'b1, {(FW-1){1'b0}}};
                w_erRnd = w_erRnd + 1'b1;
            end else begin
                w_frRnd = w_frTop + 1'b1;
            end
        end
        w_sat = (int'(w_erRnd) > EMAX);
    end

    // Control and datapath: capture, shift-normalise, round/saturate, hold until accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sh       <= '0;
            r_cnt      <= '0;
            r_s        <= 1'b0;
            r_e        <= '0;
            r_f        <= '0;
            r_sat      <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.in_valid) begin
                        r_s     <= io_bus.D[W-1];
                        r_sh    <= w_mag;
                        r_cnt   <= '0;
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (w_normDone) begin
                        r_state <= S_RND;
                    end else begin
                        r_sh  <= {r_sh[W-2:0], 1'b0};
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RND: begin
                    if (w_sat) begin
                        r_e   <= EW'(EMAX);
                        r_f   <= '1;
                        r_sat <= 1'b1;
                    end else begin
                        r_e   <= EW'(w_erRnd);
                        r_f   <= w_frRnd;
                        r_sat <= 1'b0;
                    end
                    r_outValid <= 1'b1;
                    r_state    <= S_OUT;
                end
                S_OUT: begin
                    if (io_bus.out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.in_ready  = (r_state == S_IDLE);
    assign io_bus.S         = r_s;
    assign io_bus.E         = r_e;
    assign io_bus.F         = r_f;
    assign io_bus.sat       = r_sat;
    assign io_bus.out_valid = r_outValid;
endmodule

// File: tb/tb_fpcvt_seq.sv
// Scoreboard bench for fpcvt_seq: a rounding instance and a truncating instance run in lockstep;
// the driver queues hand-computed results, a negedge monitor pops them on each output handshake.
module tb_fpcvt_seq;
    logic clk = 1'b0;
    logic rst;

    fpcvt_seq_if #(.W(12), .EW(3), .FW(4)) bus ();
    fpcvt_seq_if #(.W(12), .EW(3), .FW(4)) busTrunc ();

    assign busTrunc.D         = bus.D;
    assign busTrunc.in_valid  = bus.in_valid;
    assign busTrunc.out_ready = bus.out_ready;

    fpcvt_seq #(.W(12), .EW(3), .FW(4), .ROUND(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus.slave)
    );

    fpcvt_seq #(.W(12), .EW(3), .FW(4), .ROUND(0)) dutTrunc (
        .clk    (clk),
        .rst    (rst),
        .io_bus (busTrunc.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       s;
        logic [2:0] e;
        logic [3:0] f;
        logic       sat;
        logic [2:0] e0;
        logic [3:0] f0;
        logic       sat0;
    } exp_t;

    exp_t sbQ[$];
    int   checkCount = 0;
    int   failCount  = 0;

    // One comparison: counted always, reported only when it disagrees
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one sample, queue its expected result, and measure capture-to-out_valid latency
    task automatic applyStimulus(input logic [11:0] d, input exp_t ex, input int expLat);
        int guard;
        int lat;
        logic busyOk;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.D = d;
        bus.in_valid = 1'b1;
        sbQ.push_back(ex);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        busyOk = 1'b1;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) busyOk = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        checkOutput($sformatf("latency_%03h", d), 32'(lat), 32'(expLat));
        checkOutput($sformatf("busy_in_ready_%03h", d), 32'(busyOk), 32'd1);
    endtask

    task automatic runVec(input logic [11:0] d, input logic s, input logic [2:0] e,
                          input logic [3:0] f, input logic sat, input logic [2:0] e0,
                          input logic [3:0] f0, input logic sat0, input int lat);
        exp_t ex;
        ex = '{s: s, e: e, f: f, sat: sat, e0: e0, f0: f0, sat0: sat0};
        applyStimulus(d, ex, lat);
    endtask

    // Monitor: every accepted output is matched against the oldest queued expectation
    always @(negedge clk) begin
        exp_t ex;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpected_output", 32'd1, 32'd0);
            end else begin
                ex = sbQ.pop_front();
                checkOutput("result_round", 32'({bus.S, bus.E, bus.F, bus.sat}),
                            32'({ex.s, ex.e, ex.f, ex.sat}));
                checkOutput("result_trunc",
                            32'({busTrunc.out_valid, busTrunc.S, busTrunc.E, busTrunc.F, busTrunc.sat}),
                            32'({1'b1, ex.s, ex.e0, ex.f0, ex.sat0}));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        logic quietOk;
        rst = 1'b1;
        bus.D = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;

        #12;
        checkOutput("reset_outputs", 32'({bus.S, bus.E, bus.F, bus.sat, bus.out_valid}), 32'd0);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Consumer stalls for 5 cycles; result must hold and new samples must be ignored
        bus.out_ready = 1'b0;
        runVec(12'd422, 1'b0, 3'd5, 4'b1101, 1'b0, 3'd5, 4'b1101, 1'b0, 5);
        for (int i = 0; i < 5; i++) begin
            bus.D = 12'd125;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            checkOutput("stall_hold", 32'({bus.out_valid, bus.in_ready, bus.S, bus.E, bus.F, bus.sat}),
                        32'({1'b1, 1'b0, 1'b0, 3'd5, 4'b1101, 1'b0}));
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("after_handshake", 32'({bus.out_valid, bus.in_ready}), 32'({1'b0, 1'b1}));

        runVec(12'hF83, 1'b1, 3'd4, 4'b1000, 1'b0, 3'd3, 4'b1111, 1'b0, 7);
        runVec(12'd125, 1'b0, 3'd4, 4'b1000, 1'b0, 3'd3, 4'b1111, 1'b0, 7);
        runVec(12'h800, 1'b1, 3'd7, 4'b1111, 1'b1, 3'd7, 4'b1111, 1'b1, 2);
        runVec(12'd2047, 1'b0, 3'd7, 4'b1111, 1'b1, 3'd7, 4'b1111, 1'b0, 3);
        runVec(12'h801, 1'b1, 3'd7, 4'b1111, 1'b1, 3'd7, 4'b1111, 1'b0, 3);
        runVec(12'd0, 1'b0, 3'd0, 4'b0000, 1'b0, 3'd0, 4'b0000, 1'b0, 10);
        runVec(12'd1, 1'b0, 3'd0, 4'b0001, 1'b0, 3'd0, 4'b0001, 1'b0, 10);
        runVec(12'hFFF, 1'b1, 3'd0, 4'b0001, 1'b0, 3'd0, 4'b0001, 1'b0, 10);
        runVec(12'd15, 1'b0, 3'd0, 4'b1111, 1'b0, 3'd0, 4'b1111, 1'b0, 10);
        runVec(12'd24, 1'b0, 3'd1, 4'b1100, 1'b0, 3'd1, 4'b1100, 1'b0, 9);
        runVec(12'd23, 1'b0, 3'd1, 4'b1100, 1'b0, 3'd1, 4'b1011, 1'b0, 9);
        runVec(12'd1023, 1'b0, 3'd7, 4'b1000, 1'b0, 3'd6, 4'b1111, 1'b0, 4);
        runVec(12'd1024, 1'b0, 3'd7, 4'b1000, 1'b0, 3'd7, 4'b1000, 1'b0, 3);

        // Reset during NORM: nothing queued, so any later output is flagged by the monitor
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.D = 12'd0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_norm_now", 32'({bus.out_valid, bus.in_ready}), 32'({1'b0, 1'b1}));
        @(posedge clk); #1;
        rst = 1'b0;
        quietOk = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.out_valid) quietOk = 1'b0;
        end
        checkOutput("rst_norm_no_stale", 32'(quietOk), 32'd1);

        // Reset while a result is being held: out_valid must drop asynchronously
        bus.out_ready = 1'b0;
        bus.D = 12'd422;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        guard = 0;
        while (!bus.out_valid && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("rst_out_reached", 32'(bus.out_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_out_now", 32'({bus.out_valid, bus.in_ready}), 32'({1'b0, 1'b1}));
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;

        runVec(12'd422, 1'b0, 3'd5, 4'b1101, 1'b0, 3'd5, 4'b1101, 1'b0, 5);

        repeat (4) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
